// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write sequencer.
// LCD_INIT_EN (see lcd_ctrl) makes use of the init command helper below.
package lcd_pkg;

   typedef enum logic [2:0] {
      StPwron,
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StWait
   } lcd_state_e;

   localparam int unsigned LCD_ON_BIT = 31;
   localparam int unsigned LCD_EN_BIT = 10;
   localparam int unsigned LCD_RS_BIT = 9;
   localparam int unsigned LCD_RW_BIT = 8;

   localparam logic [7:0] CMD_FUNC_SET = 8'h38;
   localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_ENTRY    = 8'h06;

   // Clear (0x01) and home (0x02/0x03) need the long execution wait.
   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data[7:2] == 6'd0);
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] idx);
      logic [7:0] cmd;
      unique case (idx)
         2'd0:    cmd = CMD_FUNC_SET;
         2'd1:    cmd = CMD_DISP_ON;
         2'd2:    cmd = CMD_CLEAR;
         default: cmd = CMD_ENTRY;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Request handshake between the LSU I/O space and the LCD sequencer.
interface lcd_ctrl_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_rs;
   logic [7:0] req_data;

   modport master (output req_valid, output req_rs, output req_data, input req_ready);
   modport slave  (input req_valid, input req_rs, input req_data, output req_ready);
endinterface

// File: rtl/lcd_cyc_timer.sv
// Loadable down-counter; done_o is high while the count sits at zero.
module lcd_cyc_timer #(
   parameter int unsigned     Width  = 8,
   parameter logic [Width-1:0] RstVal = '0
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             done_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q <= RstVal;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// HD44780 write sequencer: SETUP -> PULSE -> HOLD -> WAIT per accepted byte.
// Define LCD_INIT_EN to add the power-on wait and automatic init command sequence.
module lcd_ctrl
   import lcd_pkg::*;
#(
   parameter int unsigned T_SETUP_CYC = 2,
   parameter int unsigned T_EN_CYC    = 12,
   parameter int unsigned T_HOLD_CYC  = 2,
   parameter int unsigned T_EXEC_CYC  = 2000,
   parameter int unsigned T_LONG_CYC  = 82000,
   parameter int unsigned T_PWRON_CYC = 750000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   lcd_ctrl_if.slave   bus,
   input  logic        lcd_on_i,
   output logic        busy_o,
   output logic [31:0] io_lcd_o
);

   localparam int unsigned CntW = $clog2(T_PWRON_CYC) + 1;

   localparam logic [CntW-1:0] SetupLd = CntW'(T_SETUP_CYC - 1);
   localparam logic [CntW-1:0] EnLd    = CntW'(T_EN_CYC - 1);
   localparam logic [CntW-1:0] HoldLd  = CntW'(T_HOLD_CYC - 1);
   localparam logic [CntW-1:0] ExecLd  = CntW'(T_EXEC_CYC - 1);
   localparam logic [CntW-1:0] LongLd  = CntW'(T_LONG_CYC - 1);

`ifdef LCD_INIT_EN
   localparam lcd_state_e      RstState = StPwron;
   localparam logic            RstReady = 1'b0;
   localparam logic [CntW-1:0] TmrRst   = CntW'(T_PWRON_CYC - 1);
`else
   localparam lcd_state_e      RstState = StIdle;
   localparam logic            RstReady = 1'b1;
   localparam logic [CntW-1:0] TmrRst   = '0;
`endif

   lcd_state_e      state_q, state_d;
   logic            rs_q, rs_d;
   logic [7:0]      data_q, data_d;
   logic            en_q, en_d;
   logic            ready_q, ready_d;
   logic            on_q;
   logic            tmr_load;
   logic [CntW-1:0] tmr_val;
   logic            tmr_done;
   logic            accept;

`ifdef LCD_INIT_EN
   logic       init_q, init_d;
   logic [1:0] init_idx_q, init_idx_d;
`endif

   lcd_cyc_timer #(
      .Width  (CntW),
      .RstVal (TmrRst)
   ) u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .done_o     (tmr_done)
   );

   assign accept = bus.req_valid && ready_q;

   always_comb begin
      state_d  = state_q;
      rs_d     = rs_q;
      data_d   = data_q;
      en_d     = en_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
`ifdef LCD_INIT_EN
      init_d     = init_q;
      init_idx_d = init_idx_q;
`endif
      unique case (state_q)
         StPwron: begin
`ifdef LCD_INIT_EN
            if (tmr_done) begin
               rs_d     = 1'b0;
               data_d   = init_cmd(2'd0);
               state_d  = StSetup;
               tmr_load = 1'b1;
               tmr_val  = SetupLd;
            end
`else
            state_d = StIdle;
`endif
         end
         StIdle: begin
            if (accept) begin
               rs_d     = bus.req_rs;
               data_d   = bus.req_data;
               state_d  = StSetup;
               tmr_load = 1'b1;
               tmr_val  = SetupLd;
            end
         end
         StSetup: begin
            if (tmr_done) begin
               en_d     = 1'b1;
               state_d  = StPulse;
               tmr_load = 1'b1;
               tmr_val  = EnLd;
            end
         end
         StPulse: begin
            if (tmr_done) begin
               en_d     = 1'b0;
               state_d  = StHold;
               tmr_load = 1'b1;
               tmr_val  = HoldLd;
            end
         end
         StHold: begin
            if (tmr_done) begin
               state_d  = StWait;
               tmr_load = 1'b1;
               tmr_val  = is_long_cmd(rs_q, data_q) ? LongLd : ExecLd;
            end
         end
         StWait: begin
            if (tmr_done) begin
`ifdef LCD_INIT_EN
               if (init_q && (init_idx_q != 2'd3)) begin
                  init_idx_d = 2'(init_idx_q + 2'd1);
                  rs_d       = 1'b0;
                  data_d     = init_cmd(init_idx_d);
                  state_d    = StSetup;
                  tmr_load   = 1'b1;
                  tmr_val    = SetupLd;
               end else begin
                  init_d  = 1'b0;
                  state_d = StIdle;
               end
`else
               state_d = StIdle;
`endif
            end
         end
         default: state_d = RstState;
      endcase
      ready_d = (state_d == StIdle);
   end

   // Reset clears EN at once, so an interrupted pulse never resumes.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= RstState;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         en_q    <= 1'b0;
         ready_q <= RstReady;
         on_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rs_q    <= rs_d;
         data_q  <= data_d;
         en_q    <= en_d;
         ready_q <= ready_d;
         on_q    <= lcd_on_i;
      end
   end

`ifdef LCD_INIT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         init_q     <= 1'b1;
         init_idx_q <= 2'd0;
      end else begin
         init_q     <= init_d;
         init_idx_q <= init_idx_d;
      end
   end
`endif

   assign bus.req_ready = ready_q;
   assign busy_o        = ~ready_q;

   always_comb begin
      io_lcd_o             = '0;
      io_lcd_o[LCD_ON_BIT] = on_q;
      io_lcd_o[LCD_EN_BIT] = en_q;
      io_lcd_o[LCD_RS_BIT] = rs_q;
      io_lcd_o[LCD_RW_BIT] = 1'b0;
      io_lcd_o[7:0]        = data_q;
   end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with short timing parameters 2/3/2/5/20/50.
module tb_lcd_ctrl;

   localparam int unsigned TS = 2;
   localparam int unsigned TE = 3;
   localparam int unsigned TH = 2;
   localparam int unsigned TX = 5;
   localparam int unsigned TL = 20;
   localparam int unsigned TP = 50;

`ifdef LCD_INIT_EN
   localparam logic RstReady = 1'b0;
`else
   localparam logic RstReady = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        lcd_on;
   logic        busy;
   logic [31:0] io_lcd;
   int          errors = 0;
   int          checks = 0;

   lcd_ctrl_if bus ();

   lcd_ctrl #(
      .T_SETUP_CYC (TS),
      .T_EN_CYC    (TE),
      .T_HOLD_CYC  (TH),
      .T_EXEC_CYC  (TX),
      .T_LONG_CYC  (TL),
      .T_PWRON_CYC (TP)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .bus      (bus),
      .lcd_on_i (lcd_on),
      .busy_o   (busy),
      .io_lcd_o (io_lcd)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int guard = 0;
      while (bus.req_ready !== 1'b1 && guard < 300) begin
         tick();
         guard++;
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      lcd_on        = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_rs    = 1'b0;
      bus.req_data  = 8'h00;
      repeat (3) tick();
      checks++;
      if (io_lcd !== 32'h0) begin
         errors++;
         $display("FAIL reset_io: got %h required %h", io_lcd, 32'h0);
      end
      checks++;
      if (bus.req_ready !== RstReady) begin
         errors++;
         $display("FAIL reset_ready: got %b required %b", bus.req_ready, RstReady);
      end
      checks++;
      if (busy !== ~RstReady) begin
         errors++;
         $display("FAIL reset_busy: got %b required %b", busy, ~RstReady);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (bus.req_ready !== RstReady) begin
         errors++;
         $display("FAIL release_ready: got %b required %b", bus.req_ready, RstReady);
      end
      checks++;
      if (io_lcd !== 32'h8000_0000) begin
         errors++;
         $display("FAIL release_io: got %h required %h", io_lcd, 32'h8000_0000);
      end
   endtask

`ifdef LCD_INIT_EN
   task automatic test_init();
      logic [7:0] want [4];
      logic [7:0] got [$];
      logic       prev_en = 1'b0;
      int         first_rise = -1;
      int         ready_at = -1;
      int         bad_rs = 0;
      want[0] = 8'h38;
      want[1] = 8'h0C;
      want[2] = 8'h01;
      want[3] = 8'h06;
      for (int c = 0; c < 400; c++) begin
         tick();
         if (io_lcd[10] === 1'b1 && prev_en !== 1'b1) begin
            if (first_rise < 0) first_rise = c;
            got.push_back(io_lcd[7:0]);
            if (io_lcd[9] !== 1'b0) bad_rs++;
         end
         prev_en = io_lcd[10];
         if (bus.req_ready === 1'b1) begin
            ready_at = c;
            break;
         end
      end
      checks++;
      if (got.size() != 4) begin
         errors++;
         $display("FAIL init_count: got %0d pulses required 4", got.size());
      end
      for (int i = 0; i < got.size() && i < 4; i++) begin
         checks++;
         if (got[i] !== want[i]) begin
            errors++;
            $display("FAIL init_cmd%0d: got %h required %h", i, got[i], want[i]);
         end
      end
      checks++;
      if (bad_rs != 0) begin
         errors++;
         $display("FAIL init_rs: %0d pulses with rs=1, required 0", bad_rs);
      end
      checks++;
      if (first_rise != 50) begin
         errors++;
         $display("FAIL init_first_en: got cycle %0d required 50", first_rise);
      end
      checks++;
      if (ready_at != 111) begin
         errors++;
         $display("FAIL init_ready: got cycle %0d required 111", ready_at);
      end
   endtask
`endif

   task automatic test_write(input logic rs, input logic [7:0] data, input int exp_ready);
      int          bad_word = 0;
      int          bad_busy = 0;
      int          ready_at = -1;
      logic [31:0] first_bad = '0;
      logic [31:0] exp_word;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_rs    = rs;
      bus.req_data  = data;
      tick();
      bus.req_valid = 1'b0;
      bus.req_rs    = ~rs;
      bus.req_data  = ~data;
      for (int k = 0; k <= 60; k++) begin
         exp_word = {1'b1, 20'b0, (k >= int'(TS) && k < int'(TS + TE)), rs, 1'b0, data};
         if (io_lcd !== exp_word) begin
            if (bad_word == 0) first_bad = io_lcd;
            bad_word++;
         end
         if (busy !== ~bus.req_ready) bad_busy++;
         if (bus.req_ready === 1'b1) begin
            ready_at = k;
            break;
         end
         tick();
      end
      checks++;
      if (bad_word != 0) begin
         errors++;
         $display("FAIL write_word rs=%b data=%h: %0d bad cycles (first %h), required 0",
                  rs, data, bad_word, first_bad);
      end
      checks++;
      if (bad_busy != 0) begin
         errors++;
         $display("FAIL write_busy rs=%b data=%h: %0d cycles busy!=~ready, required 0",
                  rs, data, bad_busy);
      end
      checks++;
      if (ready_at != exp_ready) begin
         errors++;
         $display("FAIL write_ready rs=%b data=%h: got edge %0d required %0d",
                  rs, data, ready_at, exp_ready);
      end
   endtask

   task automatic test_back_to_back();
      int         accepts [$];
      logic [7:0] caps [$];
      logic [7:0] want [$];
      int         en_rises = 0;
      logic       prev_ready;
      logic       prev_en;
      logic [7:0] presented;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_rs    = 1'b1;
      prev_ready    = bus.req_ready;
      prev_en       = io_lcd[10];
      for (int c = 0; c < 45; c++) begin
         presented    = 8'(c * 7 + 3);
         bus.req_data = presented;
         tick();
         if (prev_ready === 1'b1) begin
            accepts.push_back(c);
            caps.push_back(io_lcd[7:0]);
            want.push_back(presented);
         end
         if (io_lcd[10] === 1'b1 && prev_en !== 1'b1) en_rises++;
         prev_ready = bus.req_ready;
         prev_en    = io_lcd[10];
      end
      bus.req_valid = 1'b0;
      checks++;
      if (accepts.size() != 4) begin
         errors++;
         $display("FAIL b2b_accepts: got %0d required 4", accepts.size());
      end
      for (int i = 1; i < accepts.size(); i++) begin
         checks++;
         if (accepts[i] - accepts[i-1] != 13) begin
            errors++;
            $display("FAIL b2b_gap%0d: got %0d required 13", i, accepts[i] - accepts[i-1]);
         end
      end
      for (int i = 0; i < caps.size(); i++) begin
         checks++;
         if (caps[i] !== want[i]) begin
            errors++;
            $display("FAIL b2b_capture%0d: got %h required %h", i, caps[i], want[i]);
         end
      end
      checks++;
      if (en_rises != 4) begin
         errors++;
         $display("FAIL b2b_en_pulses: got %0d required 4", en_rises);
      end
   endtask

   task automatic test_lcd_on();
      int ready_at = -1;
      int bad_rw = 0;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_rs    = 1'b1;
      bus.req_data  = 8'h48;
      tick();
      bus.req_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (io_lcd[8] !== 1'b0) bad_rw++;
      end
      checks++;
      if (io_lcd[31] !== 1'b1) begin
         errors++;
         $display("FAIL on_before: got %b required 1", io_lcd[31]);
      end
      lcd_on = 1'b0;
      tick();
      checks++;
      if (io_lcd !== 32'h0000_0248) begin
         errors++;
         $display("FAIL on_cleared: got %h required %h", io_lcd, 32'h0000_0248);
      end
      lcd_on = 1'b1;
      tick();
      checks++;
      if (io_lcd[31] !== 1'b1) begin
         errors++;
         $display("FAIL on_restored: got %b required 1", io_lcd[31]);
      end
      for (int k = 10; k <= 40; k++) begin
         if (io_lcd[8] !== 1'b0) bad_rw++;
         if (bus.req_ready === 1'b1) begin
            ready_at = k;
            break;
         end
         tick();
      end
      checks++;
      if (ready_at != 12) begin
         errors++;
         $display("FAIL on_ready: got edge %0d required 12", ready_at);
      end
      checks++;
      if (bad_rw != 0) begin
         errors++;
         $display("FAIL on_rw: %0d cycles with RW=1, required 0", bad_rw);
      end
   endtask

   task automatic test_reset_abort();
      int en_high = 0;
      wait_ready();
      bus.req_valid = 1'b1;
      bus.req_rs    = 1'b1;
      bus.req_data  = 8'h5A;
      tick();
      bus.req_valid = 1'b0;
      repeat (3) tick();
      checks++;
      if (io_lcd[10] !== 1'b1) begin
         errors++;
         $display("FAIL abort_en_before: got %b required 1", io_lcd[10]);
      end
      rst_n = 1'b0;
      tick();
      checks++;
      if (io_lcd !== 32'h0) begin
         errors++;
         $display("FAIL abort_io: got %h required %h", io_lcd, 32'h0);
      end
      checks++;
      if (bus.req_ready !== RstReady) begin
         errors++;
         $display("FAIL abort_ready: got %b required %b", bus.req_ready, RstReady);
      end
      repeat (2) tick();
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (io_lcd[10] !== 1'b0) en_high++;
      end
      checks++;
      if (en_high != 0) begin
         errors++;
         $display("FAIL abort_no_en: got %0d EN-high cycles required 0", en_high);
      end
   endtask

   initial begin
      test_reset();
`ifdef LCD_INIT_EN
      test_init();
`endif
      test_write(1'b1, 8'h41, 12);
      test_write(1'b0, 8'h01, 27);
      test_write(1'b0, 8'h80, 12);
      test_write(1'b0, 8'h03, 27);
      test_write(1'b0, 8'h04, 12);
      test_write(1'b1, 8'h01, 12);
      test_back_to_back();
      test_lcd_on();
      test_reset_abort();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
